vsync_fsm: RTL and testbench

VSYNC_FSM -- requirements
Module: vsync_fsm

---
 rtl/vsync_fsm.sv | 111 +++++++++++
 tb/tb_vsync_fsm.sv | 132 +++++++++++++
 2 files changed

// File: rtl/vsync_fsm.sv
// rtl/vsync_fsm.sv - vertical timing FSM: VSYNC pulse, porches and pixel row addressing
module vsync_fsm #(
    parameter int PULSE_LINES   = 2,
    parameter int BP_LINES      = 29,
    parameter int ROWS          = 96,
    parameter int LINES_PER_ROW = 5,
    parameter int FP_LINES      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_tick,
    output logic [6:0] VPIXEL,
    output logic       offDisplay_V,
    output logic       VSYNC,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        P_PULSE      = 2'd0,
        Q_BACKPORCH  = 2'd1,
        R_DISPLAY    = 2'd2,
        S_FRONTPORCH = 2'd3
    } state_t;

    localparam logic [8:0] PULSE_LAST = 9'(PULSE_LINES - 1);
    localparam logic [8:0] BP_LAST    = 9'(BP_LINES - 1);
    localparam logic [8:0] FP_LAST    = 9'(FP_LINES - 1);
    localparam logic [2:0] SUB_LAST   = 3'(LINES_PER_ROW - 1);
    localparam logic [6:0] ROW_LAST   = 7'(ROWS - 1);

    state_t     state_q;
    logic [8:0] line_cnt_q;
    logic [2:0] sub_q;
    logic [6:0] vpixel_q;
    logic       frame_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= P_PULSE;
            line_cnt_q   <= '0;
            sub_q        <= '0;
            vpixel_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                P_PULSE: begin
                    if (line_tick) begin
                        if (line_cnt_q == PULSE_LAST) begin
                            state_q    <= Q_BACKPORCH;
                            line_cnt_q <= '0;
                        end else begin
                            line_cnt_q <= line_cnt_q + 9'd1;
                        end
                    end
                end
                Q_BACKPORCH: begin
                    if (line_tick) begin
                        if (line_cnt_q == BP_LAST) begin
                            state_q    <= R_DISPLAY;
                            line_cnt_q <= '0;
                        end else begin
                            line_cnt_q <= line_cnt_q + 9'd1;
                        end
                    end
                end
                R_DISPLAY: begin
                    // Each pixel row spans LINES_PER_ROW scan lines; the last row exits to the porch.
                    if (line_tick) begin
                        line_cnt_q <= line_cnt_q + 9'd1;
                        if (sub_q == SUB_LAST) begin
                            sub_q <= '0;
                            if (vpixel_q == ROW_LAST) begin
                                state_q    <= S_FRONTPORCH;
                                vpixel_q   <= '0;
                                line_cnt_q <= '0;
                            end else begin
                                vpixel_q <= vpixel_q + 7'd1;
                            end
                        end else begin
                            sub_q <= sub_q + 3'd1;
                        end
                    end
                end
                S_FRONTPORCH: begin
                    if (line_tick) begin
                        if (line_cnt_q == FP_LAST) begin
                            state_q      <= P_PULSE;
                            line_cnt_q   <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            line_cnt_q <= line_cnt_q + 9'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= P_PULSE;
                    line_cnt_q <= '0;
                    sub_q      <= '0;
                    vpixel_q   <= '0;
                end
            endcase
        end
    end

    assign VPIXEL       = vpixel_q;
    assign VSYNC        = (state_q != P_PULSE);
    assign offDisplay_V = (state_q != R_DISPLAY);
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_vsync_fsm.sv
// tb/tb_vsync_fsm.sv - scoreboard bench for vsync_fsm
module tb_vsync_fsm;

    localparam int FRAME = 2 + 29 + 96 * 5 + 10;

    logic       clk;
    logic       reset;
    logic       line_tick;
    logic [6:0] VPIXEL;
    logic       offDisplay_V;
    logic       VSYNC;
    logic       frame_done;

    typedef struct {
        logic [6:0] vp;
        logic       vs;
        logic       off;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   n_ticks;

    vsync_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .line_tick   (line_tick),
        .VPIXEL      (VPIXEL),
        .offDisplay_V(offDisplay_V),
        .VSYNC       (VSYNC),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, want, n_ticks);
        end
    endtask

    function automatic exp_t model(input int n, input logic fd);
        exp_t e;
        int p;
        p = n % FRAME;
        e.fd  = fd;
        e.vs  = (p >= 2);
        e.off = !(p >= 31 && p < 511);
        e.vp  = (p >= 31 && p < 511) ? 7'((p - 31) / 5) : 7'd0;
        return e;
    endfunction

    task automatic step(input logic rst, input logic tk);
        exp_t e;
        logic fd;
        fd = 1'b0;
        if (rst) begin
            n_ticks = 0;
        end else if (tk) begin
            n_ticks++;
            fd = (n_ticks % FRAME == 0);
        end
        exp_q.push_back(model(n_ticks, fd));
        reset     = rst;
        line_tick = tk;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        line_tick = 1'b0;
        e = exp_q.pop_front();
        check("VPIXEL", int'(VPIXEL), int'(e.vp));
        check("VSYNC", int'(VSYNC), int'(e.vs));
        check("offDisplay_V", int'(offDisplay_V), int'(e.off));
        check("frame_done", int'(frame_done), int'(e.fd));
    endtask

    task automatic ticks(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n_ticks   = 0;
        reset     = 1'b1;
        line_tick = 1'b0;
        @(posedge clk);
        #1;

        // reset, idle cycles hold everything
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // two full frames with continuous ticks
        ticks(2 * FRAME, 0);
        step(1'b0, 1'b0);

        // third frame with random spacing between ticks
        for (int i = 0; i < FRAME; i++) ticks(1, int'($urandom_range(0, 3)));

        // widely spaced ticks across the pulse/back-porch boundary
        step(1'b1, 1'b0);
        ticks(3, 3200);

        // reset with coincident tick at row 33 aborts the frame
        step(1'b1, 1'b0);
        ticks(200, 0);
        check("row_at_200", int'(VPIXEL), 33);
        step(1'b1, 1'b1);
        ticks(5, 1);

        // reset during front porch: no frame_done, full frame afterwards
        step(1'b1, 1'b0);
        ticks(515, 0);
        step(1'b1, 1'b0);
        ticks(FRAME + 3, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
